lce_run_controller: RTL and testbench
=====================================

// Module: lce_run_controller
// PURPOSE
//  Sequences a linear-code-extraction (LCE) run of the cv32e40p core in the verilator bench.
//  Counts run cycles and, once the configured delay has elapsed, suppresses id-stage pc_set.
//  Buffers fetched instruction words for the dump sink.
//  Arbitrates the end-of-run events and latches the final cycle, PC and reason.
//  Sits between the bench top, the core fetch/ID path and the file-dump side.
// PARAMETERS
//  CNT_WIDTH    32  width of cycle counter, delay and maxcycles
//  INSTR_WIDTH  32  width of captured instruction word
//  ADDR_WIDTH   32  width of PC
//  FIFO_DEPTH   8   dump FIFO entries; power of two, >=2
//  START_SKIP   2   cycles skipped after fetch enable before counting starts
// PORTS
//  clk_i            in   1            clock
//  rst_ni           in   1            async reset, active low
//  fetch_enable_i   in   1            run start
//  cfg_lce_en_i     in   1            enable extraction (capture + pc_set suppression)
//  cfg_delay_i      in   CNT_WIDTH    cycle at which pc_set suppression starts
//  cfg_max_en_i     in   1            enable maxcycles abort
//  cfg_maxcycles_i  in   CNT_WIDTH    abort threshold
//  instr_valid_i    in   1            fetch word valid this cycle
//  instr_rdata_i    in   INSTR_WIDTH  fetched instruction word
//  pc_if_i          in   ADDR_WIDTH   IF-stage PC
//  pc_set_i         in   1            id-stage pc_set request
//  pc_set_o         out  1            gated pc_set to IF stage
//  tests_passed_i   in   1            pass flag
//  tests_failed_i   in   1            fail flag
//  exit_valid_i     in   1            exit strobe
//  exit_value_i     in   32           exit code
//  alarm_i          in   1            LCE detector alarm (tie 0 if absent)
//  dump_valid_o     out  1            FIFO head valid
//  dump_ready_i     in   1            sink accepts head
//  dump_data_o      out  INSTR_WIDTH  FIFO head word
//  dump_cycle_o     out  CNT_WIDTH    cycle count when head was captured
//  cycle_cnt_o      out  CNT_WIDTH    current run cycle count
//  lce_active_o     out  1            pc_set suppression active
//  overflow_o       out  1            sticky: capture dropped because FIFO full
//  done_o           out  1            run finished, FIFO drained
//  done_reason_o    out  3            lce_ctrl_pkg::reason_e
//  final_cycle_o    out  CNT_WIDTH    cycle count at end event
//  final_pc_o       out  ADDR_WIDTH   pc_if_i at end event
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, FIFO empty, reason NONE.
//  FSM states:
//   IDLE: on fetch_enable_i, sample the cfg_* inputs into registers, then go to SKIP.
//         The sampled cfg is held for the whole run.
//   SKIP: count START_SKIP cycles, then go to RUN. The counter is held at 0.
//   RUN: counter +1 per cycle, saturating at all-ones.
//        Go to EXTRACT when lce_en && cnt >= delay.
//   EXTRACT: counter keeps incrementing; pc_set_o = 0.
//   DRAIN: counter frozen; capture stopped; pc_set_o stays 0 if the run came from EXTRACT.
//          Go to DONE when the FIFO is empty.
//   DONE: sticky until reset; done_o = 1.
//  pc_set_o = pc_set_i except in EXTRACT, and in DRAIN entered from EXTRACT, where it is 0.
//   Combinational from the registered state, so the 1-cycle effect follows the counter edge.
//  lce_active_o = 1 in exactly those states.
//  End events are checked in RUN/EXTRACT only. Priority when simultaneous:
//   ALARM > FAILED > PASSED > EXIT_OK (value==0) / EXIT_ERR (value!=0) > MAXCYC.
//  MAXCYC fires when max_en && cnt >= maxcycles.
//  On the event edge, latch reason, final_cycle_o = cnt and final_pc_o = pc_if_i; go to DRAIN.
//  Events in SKIP are ignored. Events in DRAIN/DONE are ignored; the first latch wins.
//  Capture: in RUN/EXTRACT with lce_en && instr_valid_i, push {instr_rdata_i, cnt}.
//   The capture cycle is also an end-event cycle: the word is still captured.
//  FIFO:
//   Pop when dump_valid_o && dump_ready_i; first-word-fall-through.
//   Push while full is accepted only if a pop occurs the same cycle; otherwise drop and set overflow_o.
//   Push + pop same cycle on empty: the word is pushed; dump_valid_o rises next cycle.
//   Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty are derived from them.
//  Reset mid-run: immediate return to IDLE; FIFO contents are discarded.
// STRUCTURE
//  lce_ctrl_pkg: state_e {IDLE,SKIP,RUN,EXTRACT,DRAIN,DONE};
//   reason_e {NONE,PASSED,FAILED,EXIT_OK,EXIT_ERR,MAXCYC,ALARM}.
//  Sub-module lce_dump_fifo: synchronous FIFO, parameters WIDTH and DEPTH.
// TESTING
//  1. lce_en=1, delay=10, pc_set_i=1 constant.
//     -> pc_set_o=1 through cnt=10; 0 from the cycle after cnt reaches 10; lce_active_o matches.
//  2. max_en=1, maxcycles=50, no other events.
//     -> done_reason=MAXCYC, final_cycle_o=50, final_pc_o = pc_if_i at that edge.
//  3. alarm_i and tests_passed_i in the same cycle at cnt=20.
//     -> reason=ALARM, final_cycle_o=20; a later tests_failed_i leaves it unchanged.
//  4. exit_valid_i with value=3 -> reason EXIT_ERR; with value=0 -> reason EXIT_OK.
//  5. DEPTH=8, dump_ready_i=0, 10 valid fetches.
//     -> 8 stored, overflow_o=1; release ready -> 8 words popped in order with correct cycles.
//     -> then done_o=1 after the end event.
//  6. rst_ni low in EXTRACT with 3 words queued.
//     -> all outputs 0, dump_valid_o=0, state IDLE, pc_set_o follows pc_set_i.

Source files
------------

// File: rtl/lce_ctrl_pkg.sv
// lce_ctrl_pkg: run-controller state and end-reason encodings
package lce_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SKIP, RUN, EXTRACT, DRAIN, DONE} state_e;
  typedef enum logic [2:0] {NONE, PASSED, FAILED, EXIT_OK, EXIT_ERR, MAXCYC, ALARM} reason_e;
endpackage

// File: rtl/lce_dump_fifo.sv
// lce_dump_fifo: first-word-fall-through FIFO with wrap-bit pointers and drop flag
module lce_dump_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic full, pop, wr;
  assign valid_o = wp != rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign pop = valid_o && ready_i;
  assign wr = push_i && (!full || pop);
  assign drop_o = push_i && !wr;
  assign rdata_o = mem[rp[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(pop);
    end
  always_ff @(posedge clk_i)
    if (wr) mem[wp[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/lce_run_controller.sv
// lce_run_controller: LCE run sequencing, pc_set suppression, capture FIFO and end-event latch
module lce_run_controller
  import lce_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int START_SKIP  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fetch_enable_i,
  input  logic                   cfg_lce_en_i,
  input  logic [CNT_WIDTH-1:0]   cfg_delay_i,
  input  logic                   cfg_max_en_i,
  input  logic [CNT_WIDTH-1:0]   cfg_maxcycles_i,
  input  logic                   instr_valid_i,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  input  logic [ADDR_WIDTH-1:0]  pc_if_i,
  input  logic                   pc_set_i,
  output logic                   pc_set_o,
  input  logic                   tests_passed_i,
  input  logic                   tests_failed_i,
  input  logic                   exit_valid_i,
  input  logic [31:0]            exit_value_i,
  input  logic                   alarm_i,
  output logic                   dump_valid_o,
  input  logic                   dump_ready_i,
  output logic [INSTR_WIDTH-1:0] dump_data_o,
  output logic [CNT_WIDTH-1:0]   dump_cycle_o,
  output logic [CNT_WIDTH-1:0]   cycle_cnt_o,
  output logic                   lce_active_o,
  output logic                   overflow_o,
  output logic                   done_o,
  output logic [2:0]             done_reason_o,
  output logic [CNT_WIDTH-1:0]   final_cycle_o,
  output logic [ADDR_WIDTH-1:0]  final_pc_o
);
  state_e state;
  reason_e reason, ev;
  logic from_ext, lce_en, max_en, running, push, drop;
  logic [CNT_WIDTH-1:0] cnt, delay, maxcycles;
  logic [7:0] skip_cnt;
  logic [INSTR_WIDTH+CNT_WIDTH-1:0] head;
  assign ev = alarm_i ? ALARM : tests_failed_i ? FAILED : tests_passed_i ? PASSED :
              exit_valid_i ? (exit_value_i == '0 ? EXIT_OK : EXIT_ERR) :
              (max_en && cnt >= maxcycles) ? MAXCYC : NONE;
  assign running = state == RUN || state == EXTRACT;
  assign push = running && lce_en && instr_valid_i;
  assign lce_active_o = state == EXTRACT || (state == DRAIN && from_ext);
  assign pc_set_o = pc_set_i && !lce_active_o;
  assign done_o = state == DONE;
  assign done_reason_o = reason;
  assign cycle_cnt_o = cnt;
  assign {dump_data_o, dump_cycle_o} = head;
  lce_dump_fifo #(.WIDTH(INSTR_WIDTH + CNT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({instr_rdata_i, cnt}),
    .ready_i (dump_ready_i),
    .valid_o (dump_valid_o),
    .rdata_o (head),
    .drop_o  (drop)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      reason <= NONE;
      from_ext <= 1'b0;
      lce_en <= 1'b0;
      max_en <= 1'b0;
      cnt <= '0;
      delay <= '0;
      maxcycles <= '0;
      skip_cnt <= '0;
      overflow_o <= 1'b0;
      final_cycle_o <= '0;
      final_pc_o <= '0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      case (state)
        IDLE: if (fetch_enable_i) begin
          lce_en <= cfg_lce_en_i;
          max_en <= cfg_max_en_i;
          delay <= cfg_delay_i;
          maxcycles <= cfg_maxcycles_i;
          skip_cnt <= '0;
          state <= SKIP;
        end
        SKIP: begin
          skip_cnt <= skip_cnt + 8'd1;
          if (skip_cnt == 8'(START_SKIP - 1)) state <= RUN;
        end
        RUN, EXTRACT: begin
          cnt <= cnt + CNT_WIDTH'(cnt != '1);
          if (ev != NONE) begin
            reason <= ev;
            final_cycle_o <= cnt;
            final_pc_o <= pc_if_i;
            from_ext <= state == EXTRACT;
            state <= DRAIN;
          end else if (state == RUN && lce_en && cnt >= delay) state <= EXTRACT;
        end
        DRAIN: if (!dump_valid_o) state <= DONE;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_lce_run_controller.sv
// tb_lce_run_controller: directed vector table for end events plus hand sequences for extraction, FIFO and reset
module tb_lce_run_controller;
  import lce_ctrl_pkg::*;
  logic clk = 0, rst_ni = 0, fetch_enable_i = 0, cfg_lce_en_i = 0, cfg_max_en_i = 0;
  logic [31:0] cfg_delay_i = 0, cfg_maxcycles_i = 0, instr_rdata_i = 0, pc_if_i = 0, exit_value_i = 0;
  logic instr_valid_i = 0, pc_set_i = 0, tests_passed_i = 0, tests_failed_i = 0;
  logic exit_valid_i = 0, alarm_i = 0, dump_ready_i = 0;
  logic pc_set_o, dump_valid_o, lce_active_o, overflow_o, done_o;
  logic [31:0] dump_data_o, dump_cycle_o, cycle_cnt_o, final_cycle_o, final_pc_o;
  logic [2:0] done_reason_o;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic max_en; logic [31:0] maxc; logic [31:0] at;
    logic alarm, failed, passed, exv; logic [31:0] exval;
    logic [2:0] reason; logic [31:0] cyc;
  } row_t;
  row_t rows [7];
  always #5 clk = ~clk;
  lce_run_controller dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i), .cfg_lce_en_i(cfg_lce_en_i),
    .cfg_delay_i(cfg_delay_i), .cfg_max_en_i(cfg_max_en_i), .cfg_maxcycles_i(cfg_maxcycles_i),
    .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i), .pc_if_i(pc_if_i),
    .pc_set_i(pc_set_i), .pc_set_o(pc_set_o), .tests_passed_i(tests_passed_i),
    .tests_failed_i(tests_failed_i), .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
    .alarm_i(alarm_i), .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_data_o(dump_data_o), .dump_cycle_o(dump_cycle_o), .cycle_cnt_o(cycle_cnt_o),
    .lce_active_o(lce_active_o), .overflow_o(overflow_o), .done_o(done_o),
    .done_reason_o(done_reason_o), .final_cycle_o(final_cycle_o), .final_pc_o(final_pc_o)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_ni = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
  endtask
  // leaves the bench at the first SKIP-cycle negedge, with cfg inputs scrambled to prove they were sampled
  task automatic start(input logic lce, input logic [31:0] dly, input logic men, input logic [31:0] maxc);
    cfg_lce_en_i = lce; cfg_delay_i = dly; cfg_max_en_i = men; cfg_maxcycles_i = maxc;
    fetch_enable_i = 1;
    @(negedge clk);
    fetch_enable_i = 0; cfg_lce_en_i = ~lce; cfg_delay_i = 0; cfg_max_en_i = 1; cfg_maxcycles_i = 1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rows[0] = '{1'b0, 32'd0,  32'd20, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, ALARM,    32'd20};
    rows[1] = '{1'b0, 32'd0,  32'd5,  1'b0, 1'b1, 1'b1, 1'b1, 32'd3, FAILED,   32'd5};
    rows[2] = '{1'b0, 32'd0,  32'd7,  1'b0, 1'b0, 1'b1, 1'b1, 32'd0, PASSED,   32'd7};
    rows[3] = '{1'b0, 32'd0,  32'd9,  1'b0, 1'b0, 1'b0, 1'b1, 32'd3, EXIT_ERR, 32'd9};
    rows[4] = '{1'b0, 32'd0,  32'd4,  1'b0, 1'b0, 1'b0, 1'b1, 32'd0, EXIT_OK,  32'd4};
    rows[5] = '{1'b1, 32'd50, 32'd50, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, MAXCYC,   32'd50};
    rows[6] = '{1'b1, 32'd12, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, EXIT_OK,  32'd12};
    do_reset();
    check("reset_pc_set", pc_set_o, 0);
    check("reset_dump_valid", dump_valid_o, 0);
    check("reset_active", lce_active_o, 0);
    check("reset_done", done_o, 0);
    check("reset_reason", done_reason_o, NONE);
    check("reset_cnt", cycle_cnt_o, 0);
    check("reset_final", {final_cycle_o, final_pc_o}, 0);
    // extraction starts the cycle after cnt reaches the delay
    pc_set_i = 1;
    start(1, 10, 0, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("x_cnt%0d", i), cycle_cnt_o, i < 2 ? 0 : i - 2);
      check($sformatf("x_pcset%0d", i), pc_set_o, i <= 12);
      check($sformatf("x_active%0d", i), lce_active_o, i > 12);
      @(negedge clk);
    end
    tests_passed_i = 1; instr_valid_i = 1; instr_rdata_i = 32'hBEEF;
    @(negedge clk);
    tests_passed_i = 0; instr_valid_i = 0;
    check("x_drain_pcset", pc_set_o, 0);
    check("x_drain_active", lce_active_o, 1);
    check("x_drain_done", done_o, 0);
    check("x_evcap_valid", dump_valid_o, 1);
    check("x_evcap_data", {dump_data_o, dump_cycle_o}, {32'hBEEF, 32'd14});
    dump_ready_i = 1;
    @(negedge clk);
    check("x_popped", dump_valid_o, 0);
    check("x_drain_still", lce_active_o, 1);
    @(negedge clk);
    dump_ready_i = 0;
    check("x_done", done_o, 1);
    check("x_done_pcset", pc_set_o, 1);
    check("x_done_active", lce_active_o, 0);
    check("x_reason", done_reason_o, PASSED);
    check("x_final_cycle", final_cycle_o, 14);
    pc_set_i = 0;
    // end-event vectors: one fresh run per row, event inputs held for the cycle where cnt == at
    for (int r = 0; r < 7; r++) begin
      do_reset();
      start(0, 0, rows[r].max_en, rows[r].maxc);
      for (int n = 0; n < 200 && cycle_cnt_o != rows[r].at; n++) begin
        @(negedge clk);
        pc_if_i = 32'hA000_0000 + (cycle_cnt_o << 2);
      end
      check($sformatf("row%0d_reach", r), cycle_cnt_o, rows[r].at);
      alarm_i = rows[r].alarm; tests_failed_i = rows[r].failed; tests_passed_i = rows[r].passed;
      exit_valid_i = rows[r].exv; exit_value_i = rows[r].exval;
      @(negedge clk);
      {alarm_i, tests_failed_i, tests_passed_i, exit_valid_i} = 0;
      exit_value_i = 0;
      check($sformatf("row%0d_reason", r), done_reason_o, rows[r].reason);
      check($sformatf("row%0d_cycle", r), final_cycle_o, rows[r].cyc);
      check($sformatf("row%0d_pc", r), final_pc_o, 32'hA000_0000 + (rows[r].cyc << 2));
      @(negedge clk);
      check($sformatf("row%0d_done", r), done_o, 1);
      tests_failed_i = 1;
      @(negedge clk);
      tests_failed_i = 0;
      check($sformatf("row%0d_sticky", r), {done_reason_o, final_cycle_o}, {rows[r].reason, rows[r].cyc});
    end
    // FIFO overflow with the sink stalled, then ordered drain
    do_reset();
    start(1, 1000, 0, 0);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      instr_valid_i = 1; instr_rdata_i = 32'h1000 + j;
      @(negedge clk);
    end
    instr_valid_i = 0;
    check("f_overflow", overflow_o, 1);
    check("f_head", {dump_valid_o, dump_data_o, dump_cycle_o}, {1'b1, 32'h1000, 32'd0});
    tests_passed_i = 1;
    @(negedge clk);
    tests_passed_i = 0;
    check("f_not_done", done_o, 0);
    dump_ready_i = 1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("f_pop%0d", k), {dump_valid_o, dump_data_o, dump_cycle_o}, {1'b1, 32'h1000 + k, 32'(k)});
      @(negedge clk);
    end
    check("f_empty", dump_valid_o, 0);
    for (int n = 0; n < 10 && !done_o; n++) @(negedge clk);
    dump_ready_i = 0;
    check("f_done", done_o, 1);
    check("f_final", {done_reason_o, final_cycle_o}, {PASSED, 32'd10});
    check("f_overflow_sticky", overflow_o, 1);
    // asynchronous reset in EXTRACT with queued words
    do_reset();
    pc_set_i = 1;
    start(1, 3, 0, 0);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      instr_valid_i = 1; instr_rdata_i = 32'h2000 + j;
      @(negedge clk);
    end
    instr_valid_i = 0;
    @(negedge clk);
    check("r_pre_active", lce_active_o, 1);
    check("r_pre_pcset", pc_set_o, 0);
    check("r_pre_valid", dump_valid_o, 1);
    #1 rst_ni = 0;
    #1;
    check("r_active", lce_active_o, 0);
    check("r_pcset_hi", pc_set_o, 1);
    check("r_valid", dump_valid_o, 0);
    check("r_outs", {cycle_cnt_o, final_cycle_o, final_pc_o, overflow_o, done_o, done_reason_o}, 0);
    pc_set_i = 0;
    #1 check("r_pcset_lo", pc_set_o, 0);
    @(negedge clk);
    rst_ni = 1;
    repeat (3) @(negedge clk);
    check("r_idle", {cycle_cnt_o, lce_active_o, dump_valid_o, done_o}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
